map_port_arbiter: RTL and testbench

MAP_PORT_ARBITER -- requirements
Module: map_port_arbiter

---
 rtl/map_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_map_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_port_arbiter.sv
// rtl/map_port_arbiter.sv - 4-port round-robin read arbiter for the map memory with tile extraction.
// Define MAP_ARB_PRIO0_EN to give requester 0 absolute priority (round-robin among 1-3 only).
module map_port_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk_100mhz,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [19:0] req_row,
  input  logic [23:0] req_col,
  input  logic [1:0]  map_num,
  output logic [3:0]  gnt,
  output logic [7:0]  mem_addr,
  input  logic [75:0] mem_dout,
  output logic        rsp_valid,
  output logic [1:0]  rsp_id,
  output logic [3:0]  rsp_tile,
  output logic        rsp_is_dot,
  output logic [75:0] rsp_row
);

  logic [3:0]  r_gnt;
  logic [7:0]  r_addr;
  logic [1:0]  r_last;
  logic        r_rsp_valid;
  logic [1:0]  r_rsp_id;
  logic [3:0]  r_rsp_tile;
  logic        r_rsp_is_dot;
  logic [75:0] r_rsp_row;

  logic        r_pv   [0:RD_LATENCY];
  logic [1:0]  r_pid  [0:RD_LATENCY];
  logic [5:0]  r_pcol [0:RD_LATENCY];
  logic [4:0]  r_prow [0:RD_LATENCY];

  logic [3:0]  w_elig;
  logic        w_found;
  logic [1:0]  w_idx;
  logic [1:0]  w_cand;
  logic [4:0]  w_row;
  logic [5:0]  w_col;
  logic [3:0]  w_tile;

  // A requester holding gnt this cycle is masked so a lingering req is not granted twice.
  always_comb begin
    w_elig  = req & ~r_gnt;
    w_found = 1'b0;
    w_idx   = 2'd0;
    w_cand  = 2'd0;
`ifdef MAP_ARB_PRIO0_EN
    if (w_elig[0]) begin
      w_found = 1'b1;
      w_idx   = 2'd0;
    end else begin
      for (int off = 1; off <= 4; off++) begin
        w_cand = r_last + 2'(off);
        if (!w_found && (w_cand != 2'd0) && w_elig[w_cand]) begin
          w_found = 1'b1;
          w_idx   = w_cand;
        end
      end
    end
`else
    for (int off = 1; off <= 4; off++) begin
      w_cand = r_last + 2'(off);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
`endif
  end

  always_comb begin
    w_row = req_row[4:0];
    w_col = req_col[5:0];
    case (w_idx)
      2'd1:    begin w_row = req_row[9:5];   w_col = req_col[11:6];  end
      2'd2:    begin w_row = req_row[14:10]; w_col = req_col[17:12]; end
      2'd3:    begin w_row = req_row[19:15]; w_col = req_col[23:18]; end
      default: begin w_row = req_row[4:0];   w_col = req_col[5:0];   end
    endcase
  end

  // Columns past 18 match no tile slot and rows past 22 lie outside the maze; both read as 0.
  always_comb begin
    w_tile = 4'd0;
    for (int t = 0; t < 19; t++) begin
      if (r_pcol[RD_LATENCY] == 6'(t)) w_tile = mem_dout[4*t +: 4];
    end
    if (r_prow[RD_LATENCY] > 5'd22) w_tile = 4'd0;
  end

  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      r_gnt        <= 4'd0;
      r_addr       <= 8'd0;
      r_last       <= 2'd3;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 2'd0;
      r_rsp_tile   <= 4'd0;
      r_rsp_is_dot <= 1'b0;
      r_rsp_row    <= 76'd0;
      for (int s = 0; s <= RD_LATENCY; s++) begin
        r_pv[s]   <= 1'b0;
        r_pid[s]  <= 2'd0;
        r_pcol[s] <= 6'd0;
        r_prow[s] <= 5'd0;
      end
    end else begin
      r_gnt <= w_found ? (4'b0001 << w_idx) : 4'b0000;
      if (w_found) begin
        r_addr <= {1'b0, map_num, w_row};
`ifdef MAP_ARB_PRIO0_EN
        if (w_idx != 2'd0) r_last <= w_idx;
`else
        r_last <= w_idx;
`endif
      end
      r_pv[0]   <= w_found;
      r_pid[0]  <= w_idx;
      r_pcol[0] <= w_col;
      r_prow[0] <= w_row;
      for (int s = 1; s <= RD_LATENCY; s++) begin
        r_pv[s]   <= r_pv[s-1];
        r_pid[s]  <= r_pid[s-1];
        r_pcol[s] <= r_pcol[s-1];
        r_prow[s] <= r_prow[s-1];
      end
      r_rsp_valid <= r_pv[RD_LATENCY];
      if (r_pv[RD_LATENCY]) begin
        r_rsp_id     <= r_pid[RD_LATENCY];
        r_rsp_tile   <= w_tile;
        r_rsp_is_dot <= (w_tile[3:1] == 3'b111);
        r_rsp_row    <= mem_dout;
      end
    end
  end

  assign gnt        = r_gnt;
  assign mem_addr   = r_addr;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_tile   = r_rsp_tile;
  assign rsp_is_dot = r_rsp_is_dot;
  assign rsp_row    = r_rsp_row;

endmodule

// File: tb/tb_map_port_arbiter.sv
// tb/tb_map_port_arbiter.sv - scoreboard bench for map_port_arbiter with a registered map memory model.
`timescale 1ns/1ps
module tb_map_port_arbiter;
  localparam int LAT = 1;

  logic        clk_100mhz = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [19:0] req_row = 20'd0;
  logic [23:0] req_col = 24'd0;
  logic [1:0]  map_num = 2'd0;
  logic [3:0]  gnt;
  logic [7:0]  mem_addr;
  logic [75:0] mem_dout;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_tile;
  logic        rsp_is_dot;
  logic [75:0] rsp_row;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk_100mhz = ~clk_100mhz;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  map_port_arbiter #(.RD_LATENCY(LAT)) dut (
    .clk_100mhz(clk_100mhz), .reset(reset), .req(req), .req_row(req_row),
    .req_col(req_col), .map_num(map_num), .gnt(gnt), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_tile(rsp_tile), .rsp_is_dot(rsp_is_dot), .rsp_row(rsp_row)
  );

  function automatic logic [75:0] row_data(input logic [7:0] a);
    logic [75:0] d;
    d = '0;
    for (int t = 0; t < 19; t++) d[4*t +: 4] = 4'(int'(a) * 5 + t * 7 + 3);
    return d;
  endfunction

  logic [75:0] mem_pipe [LAT];
  always @(posedge clk_100mhz) begin
    mem_pipe[0] <= row_data(mem_addr);
    for (int s = 1; s < LAT; s++) mem_pipe[s] <= mem_pipe[s-1];
  end
  assign mem_dout = mem_pipe[LAT-1];

  typedef struct {
    logic [1:0]  id;
    logic [3:0]  tile;
    logic [75:0] row;
    int          due;
  } rsp_t;

  rsp_t        sb[$];
  rsp_t        m_pend;
  rsp_t        e;
  logic [3:0]  m_gnt = 4'd0;
  logic [1:0]  m_last = 2'd3;
  logic [7:0]  m_addr = 8'd0;
  logic [7:0]  m_pend_addr = 8'd0;
  logic [4:0]  p_row;
  logic [5:0]  p_col;
  logic [75:0] p_data;
  int          p_idx;

  function automatic int pick(input logic [3:0] el, input logic [1:0] last);
    logic [1:0] c;
`ifdef MAP_ARB_PRIO0_EN
    if (el[0]) return 0;
    el[0] = 1'b0;
`endif
    for (int o = 1; o <= 4; o++) begin
      c = last + 2'(o);
      if (el[c]) return int'(c);
    end
    return -1;
  endfunction

  // Reference model: predicts next gnt/mem_addr and queues the response each grant must produce.
  always @(negedge clk_100mhz) begin
    if (!reset) begin
      m_gnt = 4'd0; m_last = 2'd3; m_addr = 8'd0;
      sb.delete();
    end else begin
      n_vec++;
      if (gnt !== m_gnt) begin n_err++; $display("FAIL sb_gnt cyc=%0d got=%b exp=%b", cyc, gnt, m_gnt); end
      if (m_gnt != 4'd0) begin
        m_addr = m_pend_addr;
        m_pend.due = cyc + LAT + 1;
        sb.push_back(m_pend);
      end
      n_vec++;
      if (mem_addr !== m_addr) begin n_err++; $display("FAIL sb_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, m_addr); end
      if (sb.size() > 0 && sb[0].due < cyc) begin
        n_vec++; n_err++;
        $display("FAIL sb_missing cyc=%0d got=no_rsp exp=id%0d", cyc, sb[0].id);
        void'(sb.pop_front());
      end
      if (rsp_valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL sb_unexpected cyc=%0d got=rsp id%0d exp=none", cyc, rsp_id);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_tile !== e.tile || rsp_row !== e.row || cyc != e.due ||
              rsp_is_dot !== (e.tile[3:1] == 3'b111)) begin
            n_err++;
            $display("FAIL sb_rsp cyc=%0d got=id%0d tile%h dot%b exp=id%0d tile%h due%0d", cyc,
                     rsp_id, rsp_tile, rsp_is_dot, e.id, e.tile, e.due);
          end
        end
      end
      p_idx = pick(req & ~m_gnt, m_last);
      if (p_idx >= 0) begin
        m_gnt = 4'b0001 << p_idx;
`ifdef MAP_ARB_PRIO0_EN
        if (p_idx != 0) m_last = 2'(p_idx);
`else
        m_last = 2'(p_idx);
`endif
        p_row = req_row[5*p_idx +: 5];
        p_col = req_col[6*p_idx +: 6];
        m_pend_addr = {1'b0, map_num, p_row};
        p_data = row_data(m_pend_addr);
        m_pend.id = 2'(p_idx);
        m_pend.row = p_data;
        m_pend.tile = 4'd0;
        if (p_col <= 6'd18 && p_row <= 5'd22) m_pend.tile = p_data[4*p_col +: 4];
      end else begin
        m_gnt = 4'd0;
      end
    end
  end

  task automatic step();
    @(posedge clk_100mhz); #1;
  endtask

  task automatic wait_gnt(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (gnt !== 4'd0) begin ok = 1'b1; return; end
      step();
    end
  endtask

  task automatic wait_rsp(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rsp_valid === 1'b1) begin ok = 1'b1; return; end
      step();
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] row, input logic [5:0] col);
    req_row[5*i +: 5] = row;
    req_col[6*i +: 6] = col;
  endtask

  task automatic test_reset();
    logic [75:0] zero76;
    zero76 = '0;
    reset = 1'b0;
    req = 4'b1111;
    repeat (3) step();
    n_vec += 7;
    if (gnt !== 4'd0)        begin n_err++; $display("FAIL rst_gnt got=%b exp=0", gnt); end
    if (rsp_valid !== 1'b0)  begin n_err++; $display("FAIL rst_valid got=%b exp=0", rsp_valid); end
    if (rsp_id !== 2'd0)     begin n_err++; $display("FAIL rst_id got=%0d exp=0", rsp_id); end
    if (rsp_tile !== 4'd0)   begin n_err++; $display("FAIL rst_tile got=%h exp=0", rsp_tile); end
    if (rsp_is_dot !== 1'b0) begin n_err++; $display("FAIL rst_dot got=%b exp=0", rsp_is_dot); end
    if (rsp_row !== zero76)  begin n_err++; $display("FAIL rst_row got=%h exp=0", rsp_row); end
    if (mem_addr !== 8'd0)   begin n_err++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
    req = 4'd0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [75:0] d;
    d = row_data(8'h25);
    set_req(1, 5'd5, 6'd3);
    map_num = 2'd1;
    req = 4'b0010;
    step();
    req = 4'b0000;
    n_vec += 2;
    if (gnt !== 4'b0010)   begin n_err++; $display("FAIL single_gnt got=%b exp=0010", gnt); end
    if (mem_addr !== 8'h25) begin n_err++; $display("FAIL single_addr got=%h exp=25", mem_addr); end
    step();
    n_vec++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_early got=%b exp=0", rsp_valid); end
    step();
    n_vec += 3;
    if (rsp_valid !== 1'b1)  begin n_err++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
    if (rsp_id !== 2'd1)     begin n_err++; $display("FAIL single_id got=%0d exp=1", rsp_id); end
    if (rsp_tile !== d[15:12]) begin n_err++; $display("FAIL single_tile got=%h exp=%h", rsp_tile, d[15:12]); end
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
`ifdef MAP_ARB_PRIO0_EN
    exp_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001};
`else
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    reset = 1'b0; step(); reset = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 5'(i + 2), 6'(i * 4));
    map_num = 2'd2;
    req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (gnt !== exp_seq[i]) begin n_err++; $display("FAIL rr_gnt%0d got=%b exp=%b", i, gnt, exp_seq[i]); end
      if (i == 4) req = 4'd0;
      step();
    end
    repeat (5) step();
  endtask

  task automatic test_boundary();
    logic [4:0]  rows [3];
    logic [5:0]  cols [3];
    logic [75:0] d;
    logic [3:0]  exp_t;
    bit ok;
    rows = '{5'd5, 5'd23, 5'd22};
    cols = '{6'd19, 6'd2, 6'd18};
    map_num = 2'd3;
    for (int k = 0; k < 3; k++) begin
      set_req(2, rows[k], cols[k]);
      d = row_data({1'b0, 2'd3, rows[k]});
      exp_t = (k == 2) ? d[75:72] : 4'd0;
      req = 4'b0100;
      wait_gnt(8, ok);
      req = 4'd0;
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL bnd_gnt%0d got=timeout exp=grant", k); end
      wait_rsp(8, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL bnd_rsp%0d got=timeout exp=rsp", k); end
      else if (rsp_tile !== exp_t) begin n_err++; $display("FAIL bnd_tile%0d got=%h exp=%h", k, rsp_tile, exp_t); end
      step();
    end
  endtask

  task automatic test_map_change();
    bit ok;
    set_req(3, 5'd9, 6'd7);
    map_num = 2'd2;
    req = 4'b1000;
    step();
    map_num = 2'd1;
    req = 4'd0;
    n_vec += 2;
    if (gnt !== 4'b1000)  begin n_err++; $display("FAIL map_gnt got=%b exp=1000", gnt); end
    if (mem_addr !== 8'h49) begin n_err++; $display("FAIL map_addr got=%h exp=49", mem_addr); end
    step();
    n_vec += 2;
    if (gnt !== 4'd0)      begin n_err++; $display("FAIL map_idle_gnt got=%b exp=0", gnt); end
    if (mem_addr !== 8'h49) begin n_err++; $display("FAIL map_hold got=%h exp=49", mem_addr); end
    wait_rsp(6, ok);
    n_vec++;
    if (!ok || rsp_row !== row_data(8'h49)) begin n_err++; $display("FAIL map_row got=%h exp=%h", rsp_row, row_data(8'h49)); end
    repeat (2) step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] nb;
    for (int c = 0; c < 300; c++) begin
      req = req & ~gnt;
      nb = 4'($urandom_range(0, 15)) & ~req;
      for (int i = 0; i < 4; i++)
        if (nb[i]) set_req(i, 5'($urandom_range(0, 23)), 6'($urandom_range(0, 20)));
      req = req | nb;
      map_num = 2'($urandom_range(0, 3));
      step();
      n_vec++;
      if ($countones(gnt) > 1) begin n_err++; $display("FAIL b2b_onehot got=%b exp=onehot", gnt); end
    end
    for (int c = 0; c < 12; c++) begin req = req & ~gnt; step(); end
    n_vec++;
    if (sb.size() != 0 || req !== 4'd0) begin n_err++; $display("FAIL b2b_drain got=%0d/%b exp=0/0", sb.size(), req); end
  endtask

  task automatic test_reset_inflight();
    bit ok;
    set_req(1, 5'd4, 6'd6);
    req = 4'b0010;
    wait_gnt(6, ok);
    req = 4'd0;
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL rif_gnt got=timeout exp=grant"); end
    step();
    reset = 1'b0;
    #1;
    n_vec += 3;
    if (gnt !== 4'd0 || mem_addr !== 8'd0) begin n_err++; $display("FAIL rif_zero got=%b/%h exp=0/0", gnt, mem_addr); end
    if (rsp_valid !== 1'b0 || rsp_tile !== 4'd0) begin n_err++; $display("FAIL rif_rsp got=%b/%h exp=0/0", rsp_valid, rsp_tile); end
    if (rsp_row !== 76'd0 || rsp_id !== 2'd0) begin n_err++; $display("FAIL rif_row got=%h exp=0", rsp_row); end
    step();
    n_vec++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rif_stale got=%b exp=0", rsp_valid); end
    step();
    reset = 1'b1;
    req = 4'b1111;
    step();
    n_vec++;
    if (gnt !== 4'b0001) begin n_err++; $display("FAIL rif_first got=%b exp=0001", gnt); end
    req = 4'd0;
    repeat (6) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_boundary();
    test_map_change();
    test_back_to_back();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
